// File: rtl/conv_window_gen.sv
// 3x3 convolution window producer: two line buffers plus a 3x3 register window over a raster pixel stream.
// Optional WIN_SOF_SYNC_EN adds pix_sof_i, which forces the accepted pixel to position (0,0).
module conv_window_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   pix_i,
  input  logic                pix_valid_i,
  output logic                pix_ready_o,
`ifdef WIN_SOF_SYNC_EN
  input  logic                pix_sof_i,
`endif
  output logic [9*DATA_W-1:0] win_o,
  output logic                win_valid_o,
  input  logic                win_ready_i,
  output logic                win_last_o
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // win_o/win_last_o stay stable while win_valid_o is high and win_ready_i is low;
  // pix_ready_o drops only in that stalled case, so the window never changes under a stall.

  logic [CW-1:0]     col_q, cur_col;
  logic [RW-1:0]     row_q, cur_row;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic              accept;
  logic              pos_valid, pos_last;

  assign pix_ready_o = !win_valid_o || win_ready_i;
  assign accept      = pix_valid_i && pix_ready_o;

  // Position of the pixel being accepted this cycle (start-of-frame overrides the counters).
  always_comb begin
    cur_col = col_q;
    cur_row = row_q;
`ifdef WIN_SOF_SYNC_EN
    if (pix_sof_i) begin
      cur_col = '0;
      cur_row = '0;
    end
`endif
  end

  assign lb0_rd    = lb0[cur_col];
  assign lb1_rd    = lb1[cur_col];
  assign pos_valid = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign pos_last  = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (cur_col == COL_LAST) begin
        col_q <= '0;
        row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_q <= cur_col + CW'(1);
        row_q <= cur_row;
      end
    end
  end

  // Line buffer contents are don't-care after reset, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[cur_col] <= lb0_rd;
      lb0[cur_col] <= pix_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb1_rd;
      win_q[1][2] <= lb0_rd;
      win_q[2][2] <= pix_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid_o <= 1'b0;
      win_last_o  <= 1'b0;
    end else if (accept) begin
      win_valid_o <= pos_valid;
      win_last_o  <= pos_last;
    end else if (win_ready_i) begin
      win_valid_o <= 1'b0;
      win_last_o  <= 1'b0;
    end
  end

  // Row-major packing, top-left element in the MSBs, newest pixel in the LSBs.
  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign win_o[(9-(3*r+c))*DATA_W-1 -: DATA_W] = win_q[r][c];
    end
  end

endmodule
